// File: rtl/blob_locator.sv
// Per-frame white-pixel blob statistics (count, bounding box, centroid) behind the binarization stage.
// Optional ROI gating is compiled in with `define BLOB_ROI_EN.
module blob_locator #(
  parameter int X_W     = 11,
  parameter int Y_W     = 11,
  parameter int CNT_W   = 19,
  parameter int MIN_PIX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bin_vsync,
  input  logic             bin_href,
  input  logic             bin_de,
  input  logic             monoc,
`ifdef BLOB_ROI_EN
  input  logic [X_W-1:0]   roi_x_min,
  input  logic [X_W-1:0]   roi_x_max,
  input  logic [Y_W-1:0]   roi_y_min,
  input  logic [Y_W-1:0]   roi_y_max,
`endif
  output logic [X_W-1:0]   blob_x_min,
  output logic [X_W-1:0]   blob_x_max,
  output logic [Y_W-1:0]   blob_y_min,
  output logic [Y_W-1:0]   blob_y_max,
  output logic [X_W-1:0]   blob_cx,
  output logic [Y_W-1:0]   blob_cy,
  output logic [CNT_W-1:0] blob_pix,
  output logic             blob_found,
  output logic             result_valid
);

  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  localparam int DW   = (SX_W > SY_W) ? SX_W : SY_W;
  localparam int IT_W = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  state_t           state;
  logic             vs_q, vs_qq, de_q, de_qq, mono_q, href_dbg_unused;
  logic             frame_edge, pix_hit, in_roi, first_frame, res_ok;
  logic [X_W-1:0]   col, xmin, xmax, sh_xmin, sh_xmax, quo_x;
  logic [Y_W-1:0]   row, ymin, ymax, sh_ymin, sh_ymax, quo_y;
  logic [CNT_W-1:0] cnt, sh_cnt, rem_x, rem_y;
  logic [SX_W-1:0]  sum_x, sh_sx;
  logic [SY_W-1:0]  sum_y, sh_sy;
  logic [DW-1:0]    num_x, num_y;
  logic [CNT_W:0]   trial_x, trial_y;
  logic             ge_x, ge_y;
  logic [IT_W-1:0]  iter;

  // Whole pixel stream is delayed one cycle so the vsync edge compare lines up with its pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0; vs_qq <= 1'b0; de_q <= 1'b0; de_qq <= 1'b0;
      mono_q <= 1'b0; href_dbg_unused <= 1'b0;
    end else begin
      vs_q <= bin_vsync; vs_qq <= vs_q; de_q <= bin_de; de_qq <= de_q;
      mono_q <= monoc; href_dbg_unused <= bin_href;
    end
  end

  assign frame_edge = vs_q & ~vs_qq;

`ifdef BLOB_ROI_EN
  logic [X_W-1:0] rx_min, rx_max;
  logic [Y_W-1:0] ry_min, ry_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_min <= '0; rx_max <= '1; ry_min <= '0; ry_max <= '1;
    end else if (frame_edge) begin
      rx_min <= roi_x_min; rx_max <= roi_x_max;
      ry_min <= roi_y_min; ry_max <= roi_y_max;
    end
  end

  assign in_roi = (col >= rx_min) && (col <= rx_max) && (row >= ry_min) && (row <= ry_max);
`else
  assign in_roi = 1'b1;
`endif

  assign pix_hit = de_q & mono_q & in_roi & ~frame_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0; row <= '0;
    end else if (frame_edge) begin
      col <= '0; row <= '0;
    end else if (de_q) begin
      if (col != {X_W{1'b1}}) col <= col + 1'b1;
    end else if (de_qq) begin
      col <= '0;
      if (row != {Y_W{1'b1}}) row <= row + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; sum_x <= '0; sum_y <= '0;
      xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
    end else if (frame_edge) begin
      cnt <= '0; sum_x <= '0; sum_y <= '0;
      xmin <= '1; xmax <= '0; ymin <= '1; ymax <= '0;
    end else if (pix_hit) begin
      if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
      sum_x <= sum_x + SX_W'(col);
      sum_y <= sum_y + SY_W'(row);
      if (col < xmin) xmin <= col;
      if (col > xmax) xmax <= col;
      if (row < ymin) ymin <= row;
      if (row > ymax) ymax <= row;
    end
  end

  // Remainder stays below the divisor, so the shifted trial fits in CNT_W+1 bits.
  assign trial_x = {rem_x, num_x[DW-1]};
  assign trial_y = {rem_y, num_y[DW-1]};
  assign ge_x    = trial_x >= {1'b0, sh_cnt};
  assign ge_y    = trial_y >= {1'b0, sh_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; first_frame <= 1'b1; res_ok <= 1'b0;
      sh_cnt <= '0; sh_sx <= '0; sh_sy <= '0;
      sh_xmin <= '0; sh_xmax <= '0; sh_ymin <= '0; sh_ymax <= '0;
      num_x <= '0; num_y <= '0; rem_x <= '0; rem_y <= '0;
      quo_x <= '0; quo_y <= '0; iter <= '0;
      blob_x_min <= '0; blob_x_max <= '0; blob_y_min <= '0; blob_y_max <= '0;
      blob_cx <= '0; blob_cy <= '0; blob_pix <= '0; blob_found <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: ;
        CHECK: begin
          num_x <= DW'(sh_sx); num_y <= DW'(sh_sy);
          rem_x <= '0; rem_y <= '0; quo_x <= '0; quo_y <= '0; iter <= '0;
          if (sh_cnt < CNT_W'(MIN_PIX)) begin
            res_ok <= 1'b0; state <= DONE;
          end else begin
            res_ok <= 1'b1; state <= DIV;
          end
        end
        DIV: begin
          rem_x <= ge_x ? CNT_W'(trial_x - {1'b0, sh_cnt}) : CNT_W'(trial_x);
          rem_y <= ge_y ? CNT_W'(trial_y - {1'b0, sh_cnt}) : CNT_W'(trial_y);
          num_x <= {num_x[DW-2:0], 1'b0};
          num_y <= {num_y[DW-2:0], 1'b0};
          quo_x <= {quo_x[X_W-2:0], ge_x};
          quo_y <= {quo_y[Y_W-2:0], ge_y};
          iter  <= iter + 1'b1;
          if (iter == IT_W'(DW - 1)) state <= DONE;
        end
        DONE: begin
          blob_pix   <= sh_cnt;
          blob_found <= res_ok;
          blob_x_min <= res_ok ? sh_xmin : '0;
          blob_x_max <= res_ok ? sh_xmax : '0;
          blob_y_min <= res_ok ? sh_ymin : '0;
          blob_y_max <= res_ok ? sh_ymax : '0;
          blob_cx    <= quo_x;
          blob_cy    <= quo_y;
          result_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new frame edge always wins: a computation still in flight is dropped.
      if (frame_edge) begin
        if (first_frame) begin
          first_frame <= 1'b0;
        end else begin
          sh_cnt <= cnt; sh_sx <= sum_x; sh_sy <= sum_y;
          sh_xmin <= xmin; sh_xmax <= xmax; sh_ymin <= ymin; sh_ymax <= ymax;
          state <= CHECK;
        end
      end
    end
  end

endmodule

// File: tb/tb_blob_locator.sv
// Scoreboard bench for blob_locator: directed frames push hand-computed results, a monitor checks each pulse.
module tb_blob_locator;

  localparam int X_W = 11;
  localparam int Y_W = 11;
  localparam int CNT_W = 19;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bin_vsync = 1'b0, bin_href = 1'b0, bin_de = 1'b0, monoc = 1'b0;
  logic [X_W-1:0]   blob_x_min, blob_x_max, blob_cx;
  logic [Y_W-1:0]   blob_y_min, blob_y_max, blob_cy;
  logic [CNT_W-1:0] blob_pix;
  logic             blob_found, result_valid;
`ifdef BLOB_ROI_EN
  logic [X_W-1:0]   roi_x_min = '0, roi_x_max = '1;
  logic [Y_W-1:0]   roi_y_min = '0, roi_y_max = '1;
`endif

  blob_locator dut (
    .clk(clk), .rst_n(rst_n),
    .bin_vsync(bin_vsync), .bin_href(bin_href), .bin_de(bin_de), .monoc(monoc),
`ifdef BLOB_ROI_EN
    .roi_x_min(roi_x_min), .roi_x_max(roi_x_max),
    .roi_y_min(roi_y_min), .roi_y_max(roi_y_max),
`endif
    .blob_x_min(blob_x_min), .blob_x_max(blob_x_max),
    .blob_y_min(blob_y_min), .blob_y_max(blob_y_max),
    .blob_cx(blob_cx), .blob_cy(blob_cy), .blob_pix(blob_pix),
    .blob_found(blob_found), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix; int xmin; int xmax; int ymin; int ymax; int cx; int cy; int found; int due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Frame content: up to two white rectangles, or a fully white frame of full_w columns.
  int rx0[2], rx1[2], ry0[2], ry1[2];
  int nrects = 0;
  int full_w = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    checkOutput({tag, ".pix"},   int'(blob_pix),   e.pix);
    checkOutput({tag, ".xmin"},  int'(blob_x_min), e.xmin);
    checkOutput({tag, ".xmax"},  int'(blob_x_max), e.xmax);
    checkOutput({tag, ".ymin"},  int'(blob_y_min), e.ymin);
    checkOutput({tag, ".ymax"},  int'(blob_y_max), e.ymax);
    checkOutput({tag, ".cx"},    int'(blob_cx),    e.cx);
    checkOutput({tag, ".cy"},    int'(blob_cy),    e.cy);
    checkOutput({tag, ".found"}, int'(blob_found), e.found);
  endtask

  function automatic int row_width(input int r);
    int w;
    if (full_w > 0) return full_w;
    w = 1;
    for (int i = 0; i < nrects; i++)
      if (r >= ry0[i] && r <= ry1[i] && rx1[i] + 1 > w) w = rx1[i] + 1;
    return w;
  endfunction

  function automatic logic is_white(input int r, input int c);
    if (full_w > 0) return 1'b1;
    for (int i = 0; i < nrects; i++)
      if (r >= ry0[i] && r <= ry1[i] && c >= rx0[i] && c <= rx1[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t mk(input int pix, xmin, xmax, ymin, ymax, cx, cy, found);
    exp_t e;
    e.pix = pix; e.xmin = xmin; e.xmax = xmax; e.ymin = ymin; e.ymax = ymax;
    e.cx = cx; e.cy = cy; e.found = found; e.due = 0;
    return e;
  endfunction

  // Streams the lines of one frame and closes it with a vsync pulse; edge_cyc is the cycle vsync is first sampled.
  task automatic applyStimulus(input int rows, output int edge_cyc);
    for (int r = 0; r < rows; r++) begin
      int w;
      w = row_width(r);
      for (int c = 0; c < w; c++) begin
        @(negedge clk); bin_de = 1'b1; bin_href = 1'b1; monoc = is_white(r, c);
      end
      @(negedge clk); bin_de = 1'b0; bin_href = 1'b0; monoc = 1'b0;
      @(negedge clk);
    end
    @(negedge clk); bin_vsync = 1'b1; edge_cyc = cyc + 1;
    @(negedge clk);
    @(negedge clk); bin_vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_at(input exp_t e, input int edge_cyc, input int lat);
    exp_t x;
    x = e;
    x.due = edge_cyc + lat;
    sb.push_back(x);
  endtask

  task automatic set_squares();
    nrects = 2; full_w = 0;
    rx0[0] = 10; rx1[0] = 13; ry0[0] = 10; ry1[0] = 13;
    rx0[1] = 50; rx1[1] = 53; ry0[1] = 10; ry1[1] = 13;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_pulse: got result_valid=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("latency", cyc, e.due);
          checkAll("result", e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d results still pending", sb.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int   ec;
    exp_t sq, zero;
    sq   = mk(32, 10, 53, 10, 13, 31, 11, 1);
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checkAll("reset", zero);
    checkOutput("reset.valid", int'(result_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frames 1 and 2: single pixel at (100,50); frame 1 is discarded, frame 2 is below MIN_PIX.
    nrects = 1; full_w = 0;
    rx0[0] = 100; rx1[0] = 100; ry0[0] = 50; ry1[0] = 50;
    applyStimulus(480, ec);
    applyStimulus(480, ec);
    expect_at(mk(1, 0, 0, 0, 0, 0, 0, 0), ec, 3);

    // 10x10 rectangle, divider path.
    rx0[0] = 200; rx1[0] = 209; ry0[0] = 300; ry1[0] = 309;
    applyStimulus(480, ec);
    expect_at(mk(100, 200, 209, 300, 309, 204, 304, 1), ec, 33);

    set_squares();
    applyStimulus(14, ec);
    expect_at(sq, ec, 33);

    // Frame 5 result is aborted by the short frame 6 ending mid-division.
    nrects = 1;
    rx0[0] = 20; rx1[0] = 23; ry0[0] = 5; ry1[0] = 8;
    applyStimulus(10, ec);
    rx0[0] = 0; rx1[0] = 15; ry0[0] = 0; ry1[0] = 0;
    applyStimulus(1, ec);
    checkAll("hold", sq);
    expect_at(mk(16, 0, 15, 0, 0, 7, 0, 1), ec, 33);
    repeat (40) @(negedge clk);

    // Reset in the middle of a division.
    set_squares();
    applyStimulus(14, ec);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAll("midreset", zero);
    checkOutput("midreset.valid", int'(result_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(14, ec);
    applyStimulus(14, ec);
    expect_at(sq, ec, 33);
    repeat (40) @(negedge clk);

`ifdef BLOB_ROI_EN
    roi_x_min = 0; roi_x_max = 9; roi_y_min = 0; roi_y_max = 9;
    nrects = 0; full_w = 0;
    applyStimulus(1, ec);
    expect_at(zero, ec, 3);
    full_w = 20;
    applyStimulus(20, ec);
    expect_at(mk(100, 0, 9, 0, 9, 4, 4, 1), ec, 33);
`endif

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
